// File: rtl/core_insn_receiver_if.sv
// Fetch-side handshake between the instruction receiver and the core pipeline.
// The receiver drives the master side; the pipeline answers with fetch_ready.
interface core_insn_receiver_if #(
    parameter int INSN_WIDTH = 16,
    parameter int PC_WIDTH   = 4
);
    logic                  fetch_valid;
    logic [INSN_WIDTH-1:0] fetch_insn;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic                  fetch_ready;

    modport master (
        output fetch_valid,
        output fetch_insn,
        output fetch_pc,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_insn,
        input  fetch_pc,
        output fetch_ready
    );
endinterface

// File: rtl/core_insn_receiver.sv
// Per-core instruction receiver: collects a frame of bus beats from the scheduler,
// writes the optional R0 init value, then streams the frame to the pipeline.
module core_insn_receiver #(
    parameter int         CORE_ID        = 0,
    parameter int         INSN_LOAD_TIME = 4,
    parameter int         INSN_BUS_WIDTH = 64,
    parameter int         INSN_WIDTH     = 16,
    parameter int         REG_WIDTH      = 8,
    parameter logic [3:0] HALT_OPC       = 4'hF,
    localparam int        N              = INSN_LOAD_TIME * INSN_BUS_WIDTH / INSN_WIDTH,
    localparam int        IPB            = INSN_BUS_WIDTH / INSN_WIDTH,
    localparam int        PC_W           = $clog2(N),
    localparam int        LC_W           = $clog2(INSN_LOAD_TIME)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LC_W-1:0]           insn_load_counter,
    input  logic [INSN_BUS_WIDTH-1:0] insn_data,
    input  logic                      init_r0_en,
    input  logic [REG_WIDTH-1:0]      init_r0,
    output logic                      ready,
    core_insn_receiver_if.master      fetch,
    input  logic                      pipe_idle,
    output logic                      r0_we,
    output logic [REG_WIDTH-1:0]      r0_data
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        EXEC,
        DRAIN
    } state_t;

    // CORE_ID only labels the instance; the ports are already this core's slices.
    if (CORE_ID < 0) begin : g_invalid_core_id
    end

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic                  init_en_q, init_en_d;
    logic [REG_WIDTH-1:0]  init_r0_q, init_r0_d;
    logic [INSN_WIDTH-1:0] slot_q [N];
    logic [INSN_WIDTH-1:0] slot_d [N];

    logic [INSN_WIDTH-1:0] cur_insn;
    logic                  cur_is_halt;
    logic                  load_done;

    assign cur_insn    = slot_q[pc_q];
    assign cur_is_halt = (cur_insn[INSN_WIDTH-1 -: 4] == HALT_OPC);
    assign load_done   = start && (insn_load_counter == LC_W'(INSN_LOAD_TIME - 1));

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        init_en_d         = init_en_q;
        init_r0_d         = init_r0_q;
        slot_d            = slot_q;
        ready             = 1'b0;
        r0_we             = 1'b0;
        fetch.fetch_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                // Beats may arrive in any order; only the last beat index closes the frame.
                if (start) begin
                    for (int k = 0; k < INSN_LOAD_TIME; k++) begin
                        if (insn_load_counter == LC_W'(k)) begin
                            for (int j = 0; j < IPB; j++) begin
                                slot_d[k*IPB + j] = insn_data[j*INSN_WIDTH +: INSN_WIDTH];
                            end
                        end
                    end
                end
                if (load_done) begin
                    state_d   = INIT;
                    init_en_d = init_r0_en;
                    init_r0_d = init_r0;
                    pc_d      = '0;
                end
            end
            INIT: begin
                r0_we   = init_en_q;
                state_d = EXEC;
            end
            EXEC: begin
                // A HALT word is never offered to the pipeline; it just ends the frame.
                if (cur_is_halt) begin
                    state_d = DRAIN;
                end else begin
                    fetch.fetch_valid = 1'b1;
                    if (fetch.fetch_ready) begin
                        if (pc_q == PC_W'(N - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (pipe_idle) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fetch.fetch_insn = cur_insn;
    assign fetch.fetch_pc   = pc_q;
    assign r0_data          = init_r0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            init_en_q <= 1'b0;
            init_r0_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            init_en_q <= init_en_d;
            init_r0_q <= init_r0_d;
        end
    end

    // The frame buffer keeps its contents across reset so stale slots stay usable.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_core_insn_receiver.sv
// Randomized scoreboard bench for core_insn_receiver: a frame-level model predicts
// the issued instruction stream and R0 writes, and monitors compare them as they appear.
module tb_core_insn_receiver;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  insn_load_counter;
    logic [63:0] insn_data;
    logic        init_r0_en;
    logic [7:0]  init_r0;
    logic        ready;
    logic        pipe_idle;
    logic        r0_we;
    logic [7:0]  r0_data;

    core_insn_receiver_if #(.INSN_WIDTH(16), .PC_WIDTH(4)) fif ();

    core_insn_receiver dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .insn_load_counter (insn_load_counter),
        .insn_data         (insn_data),
        .init_r0_en        (init_r0_en),
        .init_r0           (init_r0),
        .ready             (ready),
        .fetch             (fif),
        .pipe_idle         (pipe_idle),
        .r0_we             (r0_we),
        .r0_data           (r0_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q [$];
    logic [7:0]  r0_exp_q [$];
    logic [15:0] model_buf [N];
    bit          model_busy = 1'b0;
    int          exp_issued;
    int          exp_latency;
    bit          exp_r0_en;

    bit          prev_stall = 1'b0;
    logic [15:0] prev_insn;
    logic [3:0]  prev_pc;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string msg);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_beat(input bit no_halt);
        logic [63:0] b;
        for (int j = 0; j < 4; j++) begin
            b[j*16 +: 12]    = 12'($urandom);
            b[j*16 + 12 +: 4] = no_halt ? 4'($urandom_range(0, 14)) : 4'($urandom_range(0, 15));
        end
        return b;
    endfunction

    // Frame semantics: issue words in order until a HALT opcode or the end of the frame.
    task automatic build_program(input bit en, input logic [7:0] r0);
        model_busy = 1'b1;
        exp_issued = 0;
        for (int p = 0; p < N; p++) begin
            if (model_buf[p][15:12] == 4'hF) break;
            exp_q.push_back({4'(p), model_buf[p]});
            exp_issued++;
        end
        exp_latency = 3 + exp_issued + ((exp_issued < N) ? 1 : 0);
        exp_r0_en   = en;
        if (en) r0_exp_q.push_back(r0);
    endtask

    task automatic apply_stimulus(input logic [1:0] k, input logic [63:0] data, input bit en, input logic [7:0] r0);
        bit exp_rdy;
        start             = 1'b1;
        insn_load_counter = k;
        insn_data         = data;
        init_r0_en        = en;
        init_r0           = r0;
        exp_rdy           = !model_busy;
        if (!model_busy) begin
            for (int j = 0; j < 4; j++) model_buf[int'(k)*4 + j] = data[j*16 +: 16];
            if (k == 2'd3) build_program(en, r0);
        end
        sample();
        check_output("ready_during_beat", ready, exp_rdy);
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_state(input bit with_insn);
        check_output("rst_ready", ready, 1);
        check_output("rst_fetch_valid", fif.fetch_valid, 0);
        check_output("rst_r0_we", r0_we, 0);
        check_output("rst_r0_data", r0_data, 0);
        check_output("rst_fetch_pc", fif.fetch_pc, 0);
        if (with_insn) check_output("rst_fetch_insn", fif.fetch_insn, model_buf[0]);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        pipe_idle      = 1'b1;
        fif.fetch_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_busy = 1'b0;
        exp_q.delete();
        r0_exp_q.delete();
        sample();
        check_reset_state(0);
        tick();
    endtask

    // Runs one frame from the cycle after its completing beat until the core is free again.
    task automatic run_frame(input bit exact, input int extra, input bit rand_ready, input bit stall4,
                             input bit noise, input bit hold_drain, input bit abort7);
        int k, stall_cnt, drain_cnt, raise_k;
        bit done, aborted;
        k = 1; stall_cnt = 0; drain_cnt = 0; raise_k = -1; done = 0; aborted = 0;
        pipe_idle = !hold_drain;
        while (!done && k <= 400) begin
            if (hold_drain && !pipe_idle && drain_cnt >= 10) begin
                pipe_idle = 1'b1;
                raise_k   = k;
            end
            start = 1'b0;
            if (noise && (exp_q.size() > 0 || !pipe_idle)) begin
                start             = 1'($urandom_range(0, 1));
                insn_load_counter = 2'($urandom_range(0, 3));
                insn_data         = rand_beat(0);
                init_r0_en        = 1'b1;
                init_r0           = 8'($urandom);
            end
            if (stall4 && fif.fetch_valid && fif.fetch_pc == 4'd4 && stall_cnt < 5) begin
                fif.fetch_ready = 1'b0;
                stall_cnt++;
            end else begin
                fif.fetch_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (abort7 && fif.fetch_valid && fif.fetch_pc == 4'd7) begin
                reset           = 1'b1;
                start           = 1'b0;
                fif.fetch_ready = 1'b0;
            end
            sample();
            if (reset) begin
                tick();
                reset = 1'b0;
                exp_q.delete();
                r0_exp_q.delete();
                model_busy = 1'b0;
                sample();
                check_reset_state(1);
                aborted = 1;
                done    = 1;
            end else begin
                if (exact && extra >= 0 && k == 1) begin
                    check_output("init_ready_low", ready, 0);
                    check_output("init_r0_we", r0_we, exp_r0_en);
                end
                if (exact && extra >= 0 && k == 2) begin
                    check_output("exec_first_valid", fif.fetch_valid, exp_issued > 0);
                    check_output("exec_first_pc", fif.fetch_pc, 0);
                end
                if (hold_drain && !pipe_idle && exp_q.size() == 0) begin
                    check_output("drain_hold_ready", ready, 0);
                    drain_cnt++;
                end
                if (ready) done = 1;
            end
            if (!done) begin
                tick();
                k++;
            end
        end
        if (!done) begin
            report_fail("frame_timeout", "core never returned to ready within 400 cycles");
        end else if (!aborted) begin
            model_busy = 1'b0;
            check_output("frame_leftover", exp_q.size(), 0);
            if (exact) check_output("frame_latency", k, exp_latency + extra);
            if (hold_drain) check_output("drain_release", k, raise_k + 1);
        end
        start           = 1'b0;
        pipe_idle       = 1'b1;
        fif.fetch_ready = 1'b1;
        tick();
    endtask

    // Monitor: every accepted instruction and every R0 strobe is matched against the model.
    always @(negedge clk) begin
        logic [19:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("stall_valid", fif.fetch_valid, 1);
                check_output("stall_insn", fif.fetch_insn, prev_insn);
                check_output("stall_pc", fif.fetch_pc, prev_pc);
            end
            if (fif.fetch_valid && fif.fetch_ready) begin
                check_output("opcode_not_halt", fif.fetch_insn[15:12] == 4'hF, 0);
                if (exp_q.size() == 0) begin
                    report_fail("unexpected_issue", $sformatf("pc %0h insn %0h", fif.fetch_pc, fif.fetch_insn));
                end else begin
                    e = exp_q.pop_front();
                    check_output("issue_pc", fif.fetch_pc, e[19:16]);
                    check_output("issue_insn", fif.fetch_insn, e[15:0]);
                end
            end
            prev_stall = fif.fetch_valid && !fif.fetch_ready;
            prev_insn  = fif.fetch_insn;
            prev_pc    = fif.fetch_pc;
            if (r0_we) begin
                if (r0_exp_q.size() == 0) begin
                    report_fail("unexpected_r0_we", $sformatf("r0_data %0h", r0_data));
                end else begin
                    check_output("r0_data", r0_data, r0_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] b;
        logic [7:0]  r;
        reset             = 1'b1;
        start             = 1'b0;
        insn_load_counter = '0;
        insn_data         = '0;
        init_r0_en        = 1'b0;
        init_r0           = '0;
        pipe_idle         = 1'b1;
        fif.fetch_ready   = 1'b1;
        do_reset();

        $display("[TB] full frame with R0 init");
        for (int k = 0; k < 4; k++) apply_stimulus(2'(k), {16'(k), 16'h0003, 16'h0002, 16'h0001}, 1'b1, 8'h5A);
        run_frame(1, 0, 0, 0, 0, 0, 0);

        $display("[TB] early halt in word 3");
        for (int k = 0; k < 4; k++) begin
            b = {16'(k), 16'h0003, 16'h0002, 16'h0001};
            if (k == 0) b[63:48] = 16'hF000;
            apply_stimulus(2'(k), b, 1'b0, 8'h00);
        end
        run_frame(1, 0, 0, 0, 0, 0, 0);

        $display("[TB] pipeline stall at pc 4");
        for (int k = 0; k < 4; k++) apply_stimulus(2'(k), rand_beat(1), 1'($urandom_range(0, 1)), 8'($urandom));
        run_frame(1, 5, 0, 1, 0, 0, 0);

        $display("[TB] out-of-order beats 3,0,1,2");
        apply_stimulus(2'd3, rand_beat(0), 1'b1, 8'($urandom));
        apply_stimulus(2'd0, rand_beat(0), 1'b1, 8'($urandom));
        apply_stimulus(2'd1, rand_beat(0), 1'b1, 8'($urandom));
        apply_stimulus(2'd2, rand_beat(0), 1'b1, 8'($urandom));
        run_frame(1, -3, 0, 0, 0, 0, 0);

        $display("[TB] start noise during execution, long drain");
        for (int k = 0; k < 4; k++) apply_stimulus(2'(k), rand_beat(0), 1'b1, 8'($urandom));
        run_frame(0, 0, 1, 0, 1, 1, 0);
        apply_stimulus(2'd3, rand_beat(0), 1'b1, 8'($urandom));
        run_frame(1, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset in the middle of execution");
        for (int k = 0; k < 4; k++) apply_stimulus(2'(k), rand_beat(1), 1'b1, 8'($urandom));
        run_frame(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) apply_stimulus(2'(k), rand_beat(0), 1'b1, 8'($urandom));
        run_frame(1, 0, 0, 0, 0, 0, 0);

        $display("[TB] random frames");
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            for (int k = 0; k < 4; k++) apply_stimulus(2'(k), rand_beat(i[0]), 1'($urandom_range(0, 1)), r);
            run_frame(0, 0, 1, 0, 0, 0, 0);
        end

        check_output("final_issue_queue", exp_q.size(), 0);
        check_output("final_r0_queue", r0_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
